// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Bundles the command side (core control FSM) and the data-memory bus side
// of the load/store sequencer into one interface.
//   slave  : the sequencer view. It takes commands and bus responses in, and
//            drives status, load result and bus request fields out.
//   master : the environment view. It combines the core and the memory model,
//            driving commands and bus responses.
// Command : req_i, we_i, funct3_i, addr_i, wdata_i
// Status  : busy_o, done_o, err_o, err_cause_o, rdata_o
// Bus     : mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
//           mem_gnt_i, mem_rvalid_i, mem_rdata_i
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_i;
  logic            we_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;
  logic [1:0]      err_cause_o;
  logic [XLEN-1:0] rdata_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o, done_o, err_o, err_cause_o, rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o, done_o, err_o, err_cause_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// This block is a multicycle load/store sequencer that sits between the core
// control FSM and the data-memory bus. It accepts one command while idle. It
// checks funct3 and alignment, then drives a word-aligned request with byte
// enables and lane-replicated store data. It waits for gnt and rvalid, with a
// bus timeout. It then returns the shifted and sign/zero-extended load word
// together with a one-cycle done pulse.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : lsu_mem_ctrl_if.slave (command, status and memory bus)
// Parameters:
//   XLEN    : data/address width, fixed at 32 (RV32)
//   TIMEOUT : maximum number of REQ+WAIT cycles before a timeout error (1..255)
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  lsu_mem_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_ALIGN = 2'b01;
  localparam logic [1:0] C_F3    = 2'b10;
  localparam logic [1:0] C_TMO   = 2'b11;

  localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];

  logic [2:0]      r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [7:0]      r_cnt;
  logic [1:0]      r_cause;
  logic [XLEN-1:0] r_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_mreq;

  logic [2:0]      w_next;
  logic [1:0]      w_cause;
  logic            w_tmo;
  logic            w_capture;

  // Illegal funct3: loads reject 011/110/111, stores reject anything above SW.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > 3'b010);
    end else begin
      case (f3)
        3'b011, 3'b110, 3'b111: bad = 1'b1;
        default:                bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

  // Halfword accesses need an even address and word accesses need a 4-byte aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Loads always fetch the whole word. Stores enable only the addressed lanes.
  function automatic logic [3:0] byte_en(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [3:0] be;
    if (we) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Replicate the store data so that the enabled lanes carry it at any offset.
  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'h000000, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'h0000, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // The counter saturates, so once the limit is reached it stays reached. A load granted on the
  // last REQ cycle therefore gets exactly one WAIT cycle for its rvalid.
  assign w_tmo = (r_cnt >= TMO_LIMIT);

  // Next-state and error-cause decode.
  always_comb begin
    w_next    = r_state;
    w_cause   = C_NONE;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          if (f3_illegal(bus.we_i, bus.funct3_i)) begin
            w_next  = S_ERR;
            w_cause = C_F3;
          end else if (misaligned(bus.funct3_i, bus.addr_i[1:0])) begin
            w_next  = S_ERR;
            w_cause = C_ALIGN;
          end else begin
            w_next = S_REQ;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.mem_gnt_i) begin
          if (r_we) begin
            w_next = S_DONE;
          end else if (bus.mem_rvalid_i) begin
            w_next    = S_DONE;
            w_capture = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end else if (w_tmo) begin
          w_next  = S_ERR;
          w_cause = C_TMO;
        end else begin
          w_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (w_tmo) begin
          w_next  = S_ERR;
          w_cause = C_TMO;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, command capture, timeout counter and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= 8'd0;
      r_cause  <= C_NONE;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mreq   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req_i) begin
        r_we     <= bus.we_i;
        r_funct3 <= bus.funct3_i;
        r_addr   <= bus.addr_i;
        r_wdata  <= bus.wdata_i;
      end
      if (r_state == S_IDLE) begin
        r_cnt <= 8'd0;
      end else if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        r_rdata <= load_extract(r_funct3, r_addr[1:0], bus.mem_rdata_i);
      end
      r_cause <= (w_next == S_ERR) ? w_cause : C_NONE;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE) || (w_next == S_ERR);
      r_err   <= (w_next == S_ERR);
      r_mreq  <= (w_next == S_REQ);
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.err_cause_o = r_cause;
  assign bus.rdata_o     = r_rdata;

  // The bus fields come only from the captured command, and they are forced to zero
  // whenever no request is outstanding.
  assign bus.mem_req_o   = r_mreq;
  assign bus.mem_we_o    = r_mreq & r_we;
  assign bus.mem_be_o    = r_mreq ? byte_en(r_we, r_funct3, r_addr[1:0]) : 4'b0000;
  assign bus.mem_addr_o  = r_mreq ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_wdata_o = r_mreq ? store_data(r_funct3, r_wdata) : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl with TIMEOUT=4. Each command pushes its
// expected completion (latency, error, cause, load result) onto a scoreboard
// queue. The entry is popped and compared when done_o appears. Bus request
// fields are checked on the first request cycle. The memory model responds
// with a programmable gnt delay and rvalid delay.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  lsu_mem_ctrl_if #(.XLEN(32)) bus ();

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [1:0]  cause;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one command and act as the memory.
  //   gnt_dly : index of the request cycle that gets gnt (-1 = never)
  //   rv_dly  : cycles after gnt for rvalid (0 = same cycle, -1 = never)
  task automatic run_cmd(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rword,
                         input logic exp_err, input logic [1:0] exp_cause,
                         input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input int exp_lat, input int exp_reqs);
    exp_t e;
    int   k;
    int   reqs;
    int   gnt_at;
    bit   done_seen;
    e.err = exp_err; e.cause = exp_cause; e.rdata = exp_rdata; e.lat = exp_lat;
    q.push_back(e);
    bus.req_i = 1'b1; bus.we_i = we; bus.funct3_i = f3;
    bus.addr_i = addr; bus.wdata_i = wdata;
    @(negedge clk_i);
    // Scramble the command inputs so that the bus fields must come from the captured copy.
    bus.req_i = 1'b0; bus.we_i = ~we; bus.funct3_i = 3'b111;
    bus.addr_i = 32'hFFFF_FFFF; bus.wdata_i = ~wdata;
    k = 1; reqs = 0; gnt_at = -1; done_seen = 1'b0;
    while (!done_seen && k <= 40) begin
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
      if (bus.done_o) begin
        done_seen = 1'b1;
        e = q.pop_front();
        check({tag, " latency"}, 32'(k), 32'(e.lat));
        check({tag, " err"}, 32'(bus.err_o), 32'(e.err));
        check({tag, " cause"}, 32'(bus.err_cause_o), 32'(e.cause));
        check({tag, " rdata"}, bus.rdata_o, e.rdata);
        check({tag, " req_at_done"}, 32'(bus.mem_req_o), 32'd0);
      end else begin
        if (bus.mem_req_o) begin
          if (reqs == 0) begin
            check({tag, " addr"}, bus.mem_addr_o, {addr[31:2], 2'b00});
            check({tag, " we"}, 32'(bus.mem_we_o), 32'(we));
            check({tag, " be"}, 32'(bus.mem_be_o), 32'(exp_be));
            check({tag, " wdata"}, bus.mem_wdata_o, exp_wd);
          end
          if (reqs == gnt_dly) begin
            bus.mem_gnt_i = 1'b1;
            gnt_at = k;
          end
          reqs++;
        end
        if (gnt_at >= 0 && rv_dly >= 0 && k == gnt_at + rv_dly) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rword;
        end
        @(negedge clk_i);
        k++;
      end
    end
    check({tag, " done_seen"}, 32'(done_seen), 32'd1);
    check({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
    bus.mem_rdata_i = 32'h0;
    @(negedge clk_i);
    check({tag, " done_pulse"}, 32'(bus.done_o), 32'd0);
    check({tag, " idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = 3'b000;
    bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst err", 32'(bus.err_o), 32'd0);
    check("rst cause", 32'(bus.err_cause_o), 32'd0);
    check("rst rdata", bus.rdata_o, 32'h0);
    check("rst mreq", 32'(bus.mem_req_o), 32'd0);
    check("rst be", 32'(bus.mem_be_o), 32'd0);
    check("rst addr", bus.mem_addr_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    //       tag      we    f3      addr          wdata         gnt rv  rword          err   cause  rdata          be       wd             lat reqs
    run_cmd("SB",    1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, -1, 32'h0,         1'b0, 2'b00, 32'h0,         4'b1000, 32'hA5A5_A5A5, 2, 1);
    run_cmd("LH",    1'b0, 3'b001, 32'h0000_2002, 32'h0,         0,  1, 32'h8001_1234, 1'b0, 2'b00, 32'hFFFF_8001, 4'b1111, 32'h0,         3, 1);
    run_cmd("LWmis", 1'b0, 3'b010, 32'h0000_0001, 32'h0,         0,  1, 32'h0,         1'b1, 2'b01, 32'hFFFF_8001, 4'b1111, 32'h0,         1, 0);
    run_cmd("L011",  1'b0, 3'b011, 32'h0000_0010, 32'h0,         0,  1, 32'h0,         1'b1, 2'b10, 32'hFFFF_8001, 4'b1111, 32'h0,         1, 0);
    run_cmd("S011",  1'b1, 3'b011, 32'h0000_0000, 32'h0,         0, -1, 32'h0,         1'b1, 2'b10, 32'hFFFF_8001, 4'b1111, 32'h0,         1, 0);
    run_cmd("SHmis", 1'b1, 3'b001, 32'h0000_2001, 32'h0,         0, -1, 32'h0,         1'b1, 2'b01, 32'hFFFF_8001, 4'b1111, 32'h0,         1, 0);
    run_cmd("LBU",   1'b0, 3'b100, 32'h0000_3001, 32'h0,         0,  0, 32'h0000_F000, 1'b0, 2'b00, 32'h0000_00F0, 4'b1111, 32'h0,         2, 1);
    run_cmd("LB",    1'b0, 3'b000, 32'h0000_6003, 32'h0,         0,  1, 32'h80FF_FFFF, 1'b0, 2'b00, 32'hFFFF_FF80, 4'b1111, 32'h0,         3, 1);
    run_cmd("SH",    1'b1, 3'b001, 32'h0000_7002, 32'h0000_BEEF, 0, -1, 32'h0,         1'b0, 2'b00, 32'hFFFF_FF80, 4'b1100, 32'hBEEF_BEEF, 2, 1);
    run_cmd("LHU",   1'b0, 3'b101, 32'h0000_8000, 32'h0,         1,  2, 32'h1234_ABCD, 1'b0, 2'b00, 32'h0000_ABCD, 4'b1111, 32'h0,         5, 2);
    run_cmd("TMO",   1'b0, 3'b010, 32'h0000_4000, 32'h0,        -1, -1, 32'h0,         1'b1, 2'b11, 32'h0000_ABCD, 4'b1111, 32'h0,         6, 5);
    run_cmd("SWlate",1'b1, 3'b010, 32'h0000_5004, 32'h1234_5678, 4, -1, 32'h0,         1'b0, 2'b00, 32'h0000_ABCD, 4'b1111, 32'h1234_5678, 6, 5);
    run_cmd("LWlate",1'b0, 3'b010, 32'h0000_5008, 32'h0,         4,  1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'hDEAD_BEEF, 4'b1111, 32'h0,         7, 5);

    // Reset while a load sits in WAIT.
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.funct3_i = 3'b010;
    bus.addr_i = 32'h0000_A000; bus.wdata_i = 32'h0;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    check("RST req", 32'(bus.mem_req_o), 32'd1);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk_i);
    bus.mem_gnt_i = 1'b0;
    check("RST wait busy", 32'(bus.busy_o), 32'd1);
    check("RST wait mreq", 32'(bus.mem_req_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("RST busy", 32'(bus.busy_o), 32'd0);
    check("RST done", 32'(bus.done_o), 32'd0);
    check("RST err", 32'(bus.err_o), 32'd0);
    check("RST mreq", 32'(bus.mem_req_o), 32'd0);
    check("RST rdata", bus.rdata_o, 32'h0);
    @(negedge clk_i);
    check("RST no done", 32'(bus.done_o), 32'd0);

    run_cmd("SWpost",1'b1, 3'b010, 32'h0000_9000, 32'hCAFE_F00D, 0, -1, 32'h0,         1'b0, 2'b00, 32'h0,         4'b1111, 32'hCAFE_F00D, 2, 1);

    check("queue empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
